// File: rtl/rf_sched_pkg.sv
// rf_sched_pkg: shared constants and types for the issue scoreboard and
// the writeback arbiter.
//   NREGS/AW/DW  register file geometry (x0 is hardwired zero)
//   STARVE_MAX   consecutive LSU-lost cycles before the LSU gets priority
//   gnt_e        writeback grant encoding
//   wb_req_t     one writeback request (valid + destination + data)
package rf_sched_pkg;
  localparam int NREGS      = 32;
  localparam int AW         = 5;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 3;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_ALU  = 2'b01,
    GNT_LSU  = 2'b10
  } gnt_e;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rf_scoreboard_arb_if.sv
// rf_scoreboard_arb_if: issue, writeback and register-file write bundle.
//   slave  : the scoreboard/arbiter side (rf_scoreboard_arb)
//   master : decode/issue, ALU/LSU writeback and register-file side
interface rf_scoreboard_arb_if;
  import rf_sched_pkg::*;

  logic             issue_valid;
  logic [AW-1:0]    issue_rs1;
  logic [AW-1:0]    issue_rs2;
  logic [AW-1:0]    issue_rd;
  logic             issue_wr;
  logic             issue_ready;

  logic             alu_wb_valid;
  logic [AW-1:0]    alu_wb_rd;
  logic [DW-1:0]    alu_wb_data;
  logic             alu_wb_ready;

  logic             lsu_wb_valid;
  logic [AW-1:0]    lsu_wb_rd;
  logic [DW-1:0]    lsu_wb_data;
  logic             lsu_wb_ready;

  logic             rf_we;
  logic [AW-1:0]    rf_rd;
  logic [DW-1:0]    rf_wdata;
  logic [NREGS-1:0] busy_vec;
  logic             wb_err;

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr,
    input  alu_wb_valid, alu_wb_rd, alu_wb_data,
    input  lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
    output issue_ready, alu_wb_ready, lsu_wb_ready,
    output rf_we, rf_rd, rf_wdata, busy_vec, wb_err
  );

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr,
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    output lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
    input  issue_ready, alu_wb_ready, lsu_wb_ready,
    input  rf_we, rf_rd, rf_wdata, busy_vec, wb_err
  );
endinterface

// File: rtl/rf_wb_arb.sv
// rf_wb_arb: two-requester writeback arbiter (ALU, LSU) with LSU
// starvation protection and granted-payload mux.
//   clk, rst_n     clock / async active-low reset
//   alu, lsu       writeback requests
//   gnt            grant for this cycle (combinational)
//   gnt_rd/data    granted payload, zero when nothing is granted
module rf_wb_arb
  import rf_sched_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  wb_req_t       alu,
  input  wb_req_t       lsu,
  output gnt_e          gnt,
  output logic [AW-1:0] gnt_rd,
  output logic [DW-1:0] gnt_data
);
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt;
  logic          lsu_pri;

  // Once the LSU has lost STARVE_MAX cycles in a row it outranks the ALU.
  assign lsu_pri = (cnt == CW'(STARVE_MAX));

  always_comb begin
    gnt = GNT_NONE;
    if (lsu.valid && (lsu_pri || !alu.valid)) gnt = GNT_LSU;
    else if (alu.valid)                       gnt = GNT_ALU;
  end

  always_comb begin
    gnt_rd   = '0;
    gnt_data = '0;
    case (gnt)
      GNT_ALU: begin gnt_rd = alu.rd; gnt_data = alu.data; end
      GNT_LSU: begin gnt_rd = lsu.rd; gnt_data = lsu.data; end
      default: ;
    endcase
  end

  // Counts consecutive cycles the LSU waited; saturates at STARVE_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             cnt <= '0;
    else if (lsu.valid && gnt != GNT_LSU) begin
      if (!lsu_pri)                         cnt <= cnt + 1'b1;
    end else                                cnt <= '0;
  end
endmodule

// File: rtl/rf_scoreboard_arb.sv
// rf_scoreboard_arb: issue-stage register scoreboard plus writeback
// arbitration onto the single register-file write port.
//   clk, rst_n   clock / async active-low reset
//   sb           issue, ALU/LSU writeback, rf write port, busy_vec, wb_err
//   stall_cnt    (SB_STATS_EN) cycles with issue_valid & ~issue_ready
//   conflict_cnt (SB_STATS_EN) cycles with both writeback valids high
// Optional feature macro: SB_STATS_EN.
module rf_scoreboard_arb
  import rf_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  rf_scoreboard_arb_if.slave sb
`ifdef SB_STATS_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        conflict_cnt
`endif
);
  wb_req_t          alu_req, lsu_req;
  gnt_e             gnt;
  logic [AW-1:0]    wrd;
  logic [DW-1:0]    wdata;
  logic [NREGS-1:0] busy, eff_busy, clr_mask, set_mask;
  logic             we, err, ready, fire, hz1, hz2, hzd;

  assign alu_req = '{valid: sb.alu_wb_valid, rd: sb.alu_wb_rd, data: sb.alu_wb_data};
  assign lsu_req = '{valid: sb.lsu_wb_valid, rd: sb.lsu_wb_rd, data: sb.lsu_wb_data};

  rf_wb_arb u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu      (alu_req),
    .lsu      (lsu_req),
    .gnt      (gnt),
    .gnt_rd   (wrd),
    .gnt_data (wdata)
  );

  // A grant to x0 still completes the handshake, it just never writes.
  assign we       = (gnt != GNT_NONE) && (wrd != '0);
  assign clr_mask = we ? (NREGS'(1) << wrd) : '0;

  // The register file bypasses same-cycle writes to reads, so a register
  // being written back right now is already safe to consume.
  assign eff_busy = busy & ~clr_mask;

  assign hz1   = (sb.issue_rs1 != '0) && eff_busy[sb.issue_rs1];
  assign hz2   = (sb.issue_rs2 != '0) && eff_busy[sb.issue_rs2];
  assign hzd   = sb.issue_wr && (sb.issue_rd != '0) && eff_busy[sb.issue_rd];
  assign ready = !(hz1 || hz2 || hzd);
  assign fire  = sb.issue_valid && ready;

  assign set_mask = (fire && sb.issue_wr && sb.issue_rd != '0) ?
                    (NREGS'(1) << sb.issue_rd) : '0;

  // Set applied after clear: a new producer issued in the same cycle as
  // the old one's writeback keeps the register busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
      if (we && !busy[wrd]) err <= 1'b1;
    end
  end

  assign sb.issue_ready  = ready;
  assign sb.alu_wb_ready = (gnt == GNT_ALU);
  assign sb.lsu_wb_ready = (gnt == GNT_LSU);
  assign sb.rf_we        = we;
  assign sb.rf_rd        = wrd;
  assign sb.rf_wdata     = wdata;
  assign sb.busy_vec     = busy;
  assign sb.wb_err       = err;

`ifdef SB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (sb.issue_valid && !ready)           stall_cnt    <= stall_cnt + 1'b1;
      if (sb.alu_wb_valid && sb.lsu_wb_valid) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`endif
endmodule
